// File: rtl/kl8e_printer_pkg.sv
// Shared constants for the KL8E console printer: CPU major-state encodings,
// device-04 IOT opcodes and the baud divisor helper.
package kl8e_printer_pkg;

    localparam logic [4:0] STATE_F1 = 5'd1;
    localparam logic [4:0] STATE_F2 = 5'd2;
    localparam logic [4:0] STATE_F3 = 5'd3;

    localparam logic [11:0] IOT_CAF = 12'o6007;
    localparam logic [11:0] IOT_SPF = 12'o6040;
    localparam logic [11:0] IOT_TSF = 12'o6041;
    localparam logic [11:0] IOT_TCF = 12'o6042;
    localparam logic [11:0] IOT_TPC = 12'o6044;
    localparam logic [11:0] IOT_SPI = 12'o6045;
    localparam logic [11:0] IOT_TLS = 12'o6046;

    // Truncated clocks-per-bit, never below 2.
    function automatic int baud_div(input int clock_freq, input int baud);
        int d;
        d = clock_freq / baud;
        return (d < 2) ? 2 : d;
    endfunction

endpackage

// File: rtl/kl8e_printer_uart_tx_core.sv
// 8N1 serialiser: start bit, eight data bits LSB first, stop bit, each DIV clocks.
//
// state   | meaning
// S_IDLE  | line high, waiting for load
// S_START | driving start bit (0)
// S_DATA  | shifting out data bits, bit_idx 0..7
// S_STOP  | driving stop bit (1); done pulses on its last clock
module kl8e_printer_uart_tx_core #(
    parameter int DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx,
    output logic       done
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       fsm;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             cnt_end;

    assign cnt_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (load) begin
                        fsm     <= S_START;
                        shreg   <= data;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                S_START: begin
                    if (cnt_end) begin
                        fsm <= S_DATA;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            fsm <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt_end) begin
                        fsm <= S_IDLE;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        if (fsm == S_START) begin
            tx = 1'b0;
        end else if (fsm == S_DATA) begin
            tx = shreg[0];
        end
    end

    assign busy = (fsm != S_IDLE);
    assign done = (fsm == S_STOP) && cnt_end;

endmodule

// File: rtl/kl8e_printer.sv
// KL8E console printer (device 04): IOT decode, printer flag, skip and serial TX.
// Optional interrupt enable (6045 SPI, int_req) is built when KL8E_INT_EN is defined.
// Vectors are numbered [11:0]; PDP-8 bit 0 (MSB) is [11], so AC bits 4:11 are ac[7:0].
module kl8e_printer #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD       = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  state,
    input  logic [11:0] instruction,
    input  logic [11:0] ac,
    output logic        tx,
    output logic        tx_skip,
    output logic        busy,
    output logic        int_req
);
    import kl8e_printer_pkg::*;

    localparam int DIV = baud_div(CLOCK_FREQ, BAUD);

    logic f3;
    logic iot_spf, iot_tcf, iot_tpc, iot_tls, iot_caf;
    logic flag;
    logic frame_done;
    logic unused_ac_hi;

    assign f3      = (state == STATE_F3);
    assign iot_spf = f3 && (instruction == IOT_SPF);
    assign iot_tcf = f3 && (instruction == IOT_TCF);
    assign iot_tpc = f3 && (instruction == IOT_TPC);
    assign iot_tls = f3 && (instruction == IOT_TLS);
    assign iot_caf = f3 && (instruction == IOT_CAF);

    assign unused_ac_hi = ^ac[11:8];

    // The core ignores load while busy, which discards a TPC/TLS mid-frame.
    kl8e_printer_uart_tx_core #(
        .DIV (DIV)
    ) u_tx_core (
        .clk   (clk),
        .rst_n (reset),
        .load  (iot_tpc || iot_tls),
        .data  (ac[7:0]),
        .busy  (busy),
        .tx    (tx),
        .done  (frame_done)
    );

    // A clear on the end-of-frame edge beats the set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag <= 1'b0;
        end else if (iot_tcf || iot_tls || iot_caf) begin
            flag <= 1'b0;
        end else if (iot_spf || frame_done) begin
            flag <= 1'b1;
        end
    end

    assign tx_skip = (instruction == IOT_TSF) && flag;

`ifdef KL8E_INT_EN
    logic iot_spi;
    logic ie;

    assign iot_spi = f3 && (instruction == IOT_SPI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie      <= 1'b1;
            int_req <= 1'b0;
        end else begin
            if (iot_spi) begin
                ie <= ac[0];
            end else if (iot_caf) begin
                ie <= 1'b1;
            end
            int_req <= flag && ie;
        end
    end
`else
    assign int_req = 1'b0;
`endif

endmodule

// File: tb/tb_kl8e_printer.sv
// Randomized bench for kl8e_printer against a frame-timeline reference model.
module tb_kl8e_printer;
    import kl8e_printer_pkg::*;

    localparam int CF  = 1000;
    localparam int BD  = 100;
    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  state = STATE_F2;
    logic [11:0] instruction = IOT_TSF;
    logic [11:0] ac = '0;
    logic        tx, tx_skip, busy, int_req;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    kl8e_printer #(.CLOCK_FREQ(CF), .BAUD(BD)) dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .instruction (instruction),
        .ac          (ac),
        .tx          (tx),
        .tx_skip     (tx_skip),
        .busy        (busy),
        .int_req     (int_req)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a start time and a byte; the line level is
    // derived from how many bit periods have elapsed since the load edge.
    int       cyc = 0;
    bit       m_active = 0;
    int       m_start = 0;
    logic [7:0] m_data = '0;
    bit       m_flag = 0;
    bit       m_ie = 1;
    bit       m_int = 0;
    bit       chk_en = 0;

    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = (cyc - m_start) / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_data[k-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit f3, done, was_busy;
        cyc++;
        if (!reset) begin
            m_active = 0;
            m_flag   = 0;
            m_ie     = 1;
            m_int    = 0;
        end else begin
            f3 = (state == STATE_F3);
`ifdef KL8E_INT_EN
            m_int = m_flag && m_ie;
`endif
            done     = m_active && ((cyc - m_start) == 10 * DIV);
            was_busy = m_active;
            if (done) m_active = 0;
            if (f3 && (instruction == IOT_TCF || instruction == IOT_TLS || instruction == IOT_CAF))
                m_flag = 0;
            else if (done || (f3 && instruction == IOT_SPF))
                m_flag = 1;
`ifdef KL8E_INT_EN
            if (f3 && instruction == IOT_SPI) m_ie = ac[0];
            else if (f3 && instruction == IOT_CAF) m_ie = 1;
`endif
            if (f3 && (instruction == IOT_TPC || instruction == IOT_TLS) && !was_busy) begin
                m_active = 1;
                m_start  = cyc;
                m_data   = ac[7:0];
            end
        end
        #1;
        if (chk_en) begin
            check("tx", tx, exp_tx());
            check("busy", busy, m_active);
            check("tx_skip", tx_skip, (instruction == IOT_TSF) && m_flag);
            check("int_req", int_req, m_int);
        end
    end

    task automatic step(input logic [4:0] st, input logic [11:0] ins, input logic [11:0] a);
        @(negedge clk);
        state = st;
        instruction = ins;
        ac = a;
    endtask

    task automatic iot(input logic [11:0] ins, input logic [11:0] a);
        step(STATE_F3, ins, a);
    endtask

    task automatic wait_tsf(input int n);
        for (int i = 0; i < n; i++) step(STATE_F2, IOT_TSF, 12'($urandom));
    endtask

    function automatic logic [11:0] rand_op();
        case ($urandom_range(0, 8))
            0: return IOT_CAF;
            1: return IOT_SPF;
            2: return IOT_TSF;
            3: return IOT_TCF;
            4: return IOT_TPC;
            5: return IOT_SPI;
            6: return IOT_TLS;
            7: return 12'o6043;
            default: return 12'($urandom);
        endcase
    endfunction

    // Any instruction with a non-F3 state must have no effect.
    task automatic idle_rand(input int n);
        logic [4:0] st;
        for (int i = 0; i < n; i++) begin
            st = 5'($urandom_range(0, 31));
            if (st == STATE_F3) st = STATE_F2;
            step(st, rand_op(), 12'($urandom));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_skip", tx_skip, 1'b0);
        check("rst_int", int_req, 1'b0);
        reset = 1'b1;
        chk_en = 1'b1;

        // Frame of 0101 via TLS; flag sets on edge 100 after the load.
        iot(IOT_TLS, 12'o0101);
        wait_tsf(100);
        #1;
        check("t1_busy_last", busy, 1'b1);
        check("t1_skip_before", tx_skip, 1'b0);
        wait_tsf(1);
        #1;
        check("t1_busy_end", busy, 1'b0);
        check("t2_skip_set", tx_skip, 1'b1);
        iot(IOT_TCF, 12'o0);
        wait_tsf(1);
        #1;
        check("t2_skip_clr", tx_skip, 1'b0);

        // TPC mid-frame is discarded; TLS mid-frame only clears the flag.
        iot(IOT_TPC, 12'o0101);
        wait_tsf(20);
        iot(IOT_TPC, 12'o0125);
        wait_tsf(20);
        iot(IOT_SPF, 12'o0);
        wait_tsf(1);
        #1;
        check("t3_spf", tx_skip, 1'b1);
        iot(IOT_TLS, 12'o0125);
        wait_tsf(1);
        #1;
        check("t3_tls_clr", tx_skip, 1'b0);
        wait_tsf(60);
        #1;
        check("t3_flag_end", tx_skip, 1'b1);
        wait_tsf(5);
        #1;
        check("t3_no_second", busy, 1'b0);

        // Reset during the fourth data bit.
        iot(IOT_TPC, 12'o0101);
        wait_tsf(44);
        #1;
        check("t4_mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t4_rst_tx", tx, 1'b1);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_flag", tx_skip, 1'b0);
        wait_tsf(3);
        reset = 1'b1;
        iot(IOT_TLS, 12'($urandom));
        wait_tsf(101);
        #1;
        check("t4_refrm_flag", tx_skip, 1'b1);

        // Clear versus set on the end-of-frame edge.
        iot(IOT_TLS, 12'($urandom));
        wait_tsf(99);
        iot(IOT_TCF, 12'o0);
        wait_tsf(1);
        #1;
        check("t5_tcf_wins", tx_skip, 1'b0);
        iot(IOT_TLS, 12'($urandom));
        wait_tsf(99);
        iot(IOT_SPF, 12'o0);
        wait_tsf(1);
        #1;
        check("t5_spf_set", tx_skip, 1'b1);

        // Interrupt enable sequence (int_req stays 0 without the feature).
        iot(IOT_SPI, 12'o0);
        iot(IOT_TLS, 12'($urandom));
        wait_tsf(105);
        #1;
        check("t6_ie0", int_req, 1'b0);
        iot(IOT_SPI, 12'o1);
        wait_tsf(1);
        wait_tsf(1);
        #1;
`ifdef KL8E_INT_EN
        check("t6_ie1", int_req, 1'b1);
`else
        check("t6_ie1", int_req, 1'b0);
`endif
        iot(IOT_CAF, 12'o0);
        wait_tsf(2);
        #1;
        check("t6_caf_flag", tx_skip, 1'b0);
        check("t6_caf_int", int_req, 1'b0);

        // Random mix of F3 IOTs and non-F3 traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) iot(rand_op(), 12'($urandom));
            else idle_rand(1);
        end
        wait_tsf(120);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
